// File: rtl/mem_pkg.sv
// Shared encodings and types for the load/store unit: access-mode codes,
// controller state and access-size classification.
package mem_pkg;

    localparam logic [2:0] MEM_B    = 3'b000;
    localparam logic [2:0] MEM_H    = 3'b001;
    localparam logic [2:0] MEM_W    = 3'b010;
    localparam logic [2:0] MEM_BU   = 3'b011;
    localparam logic [2:0] MEM_HU   = 3'b100;
    localparam logic [2:0] MEM_NONE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Unlisted codes (101, 110) fall through to a full-word access.
    function automatic acc_size_t acc_size(input logic [2:0] mode);
        case (mode)
            MEM_B, MEM_BU: acc_size = SZ_BYTE;
            MEM_H, MEM_HU: acc_size = SZ_HALF;
            default:       acc_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load-data formatter: picks the addressed byte/half lane out of the bus word
// and sign- or zero-extends it to 32 bits according to the access mode.
module lsu_load_fmt
    import mem_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (mode_i)
            MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  data_o = {24'h000000, byte_sel};
            MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  data_o = {16'h0000, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: converts core-side accesses into word-aligned
// req/ack bus transactions with byte strobes and stalls the core until done.
module lsu_bus_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        mem_acc_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        mode_q;
    logic [1:0]        lane_q;
    logic [31:0]       rdata_q;
    logic              bus_err_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;

    logic        req;
    logic        aligned;
    logic        timeout_hit;
    logic [2:0]  eff_mode;
    acc_size_t   size;
    logic [3:0]  strb;
    logic [31:0] wdata_rep;
    logic [31:0] fmt_data;

    // A store wins when both enables are high; unsigned modes mean nothing to a store.
    always_comb begin
        eff_mode = mem_acc_mode;
        if (wr_en && mem_acc_mode == MEM_BU) begin
            eff_mode = MEM_B;
        end else if (wr_en && mem_acc_mode == MEM_HU) begin
            eff_mode = MEM_H;
        end
    end

    assign req         = (rd_en | wr_en) && (mem_acc_mode != MEM_NONE);
    assign size        = acc_size(eff_mode);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        aligned   = 1'b1;
        strb      = 4'b0000;
        wdata_rep = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                strb      = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                aligned   = ~addr[0];
                strb      = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                aligned   = (addr[1:0] == 2'b00);
                strb      = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
        if (!wr_en) begin
            strb      = 4'b0000;
            wdata_rep = 32'h0000_0000;
        end
    end

    lsu_load_fmt u_load_fmt (
        .mode_i (mode_q),
        .lane_i (lane_q),
        .word_i (mem_rdata),
        .data_o (fmt_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req && aligned) state_d = BUS;
            BUS:     if (mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    stall    = req && aligned;
                    misalign = req && !aligned;
                end
                BUS:     stall = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mode_q      <= MEM_W;
            lane_q      <= 2'b00;
            rdata_q     <= 32'h0000_0000;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req && aligned) begin
                        mode_q      <= eff_mode;
                        lane_q      <= addr[1:0];
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= wr_en;
                        mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= wdata_rep;
                        mem_wstrb_q <= strb;
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_ack || timeout_hit) begin
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        rdata_q     <= mem_ack ? fmt_data : 32'h0000_0000;
                        bus_err_q   <= ~mem_ack;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: stimulus queues expected bus requests,
// DONE results and misalign pulses; a negedge monitor pops and compares.
module tb_lsu_bus_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [2:0]  mem_acc_mode;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    lsu_bus_ctrl #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .mem_acc_mode (mem_acc_mode),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall_len;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    bit   mis_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: DUT event with no expected entry (got 1 expected 0)", name);
    endtask

    function automatic req_t mk_req(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] s);
        req_t r;
        r.addr = a; r.we = we; r.wdata = wd; r.strb = s;
        return r;
    endfunction

    function automatic rsp_t mk_rsp(input logic [31:0] d, input logic e, input int n);
        rsp_t r;
        r.rdata = d; r.err = e; r.stall_len = n;
        return r;
    endfunction

    // Monitor: compares bus requests on mem_req rise, results on stall fall (DONE).
    initial begin
        int   run;
        logic prev_stall;
        logic prev_req;
        req_t er;
        rsp_t es;
        run = 0; prev_stall = 1'b0; prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0; prev_stall = 1'b0; prev_req = 1'b0;
            end else begin
                if (mem_req && !prev_req) begin
                    if (req_q.size() == 0) unexpected("mem_req");
                    else begin
                        er = req_q.pop_front();
                        check("req_addr", mem_addr, er.addr);
                        check("req_we", 32'(mem_we), 32'(er.we));
                        check("req_wdata", mem_wdata, er.wdata);
                        check("req_wstrb", 32'(mem_wstrb), 32'(er.strb));
                    end
                end
                if (misalign) begin
                    if (mis_q.size() == 0) unexpected("misalign");
                    else begin
                        void'(mis_q.pop_front());
                        check("misalign_stall", 32'(stall), 32'd0);
                    end
                end
                if (stall) begin
                    run++;
                end else if (prev_stall) begin
                    if (rsp_q.size() == 0) unexpected("done");
                    else begin
                        es = rsp_q.pop_front();
                        check("done_rdata", rdata, es.rdata);
                        check("done_bus_err", 32'(bus_err), 32'(es.err));
                        check("done_stall_len", 32'(run), 32'(es.stall_len));
                    end
                    run = 0;
                end
                if (bus_err && !(prev_stall && !stall)) unexpected("bus_err");
                prev_stall = stall;
                prev_req   = mem_req;
            end
        end
    end

    // ack_dly < 0 means never acknowledge (timeout path).
    task automatic access(input logic rd, input logic wr, input logic [2:0] mode,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_dly, input logic [31:0] rword);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; mem_acc_mode = mode; addr = a; wdata = wd;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; mem_acc_mode = 3'b111; addr = 32'h0; wdata = 32'h0;
        if (ack_dly < 0) begin
            repeat (TO) begin @(posedge clk); #1; end
        end else begin
            repeat (ack_dly) begin @(posedge clk); #1; end
            mem_ack = 1'b1; mem_rdata = rword;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'h0;
        end
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [2:0] mode, input logic [31:0] a, input int dly,
                        input logic [31:0] rword, input logic [31:0] exp);
        req_q.push_back(mk_req({a[31:2], 2'b00}, 1'b0, 32'h0, 4'b0000));
        rsp_q.push_back(mk_rsp(exp, 1'b0, dly + 2));
        access(1'b1, 1'b0, mode, a, 32'h0, dly, rword);
    endtask

    task automatic store(input logic rd, input logic [2:0] mode, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_wd, input logic [3:0] exp_s);
        req_q.push_back(mk_req({a[31:2], 2'b00}, 1'b1, exp_wd, exp_s));
        rsp_q.push_back(mk_rsp(32'h0, 1'b0, 2));
        access(rd, 1'b1, mode, a, wd, 0, 32'h0);
    endtask

    task automatic bad_align(input logic rd, input logic wr, input logic [2:0] mode, input logic [31:0] a);
        mis_q.push_back(1'b1);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; mem_acc_mode = mode; addr = a; wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; mem_acc_mode = 3'b111; addr = 32'h0; wdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; mem_acc_mode = 3'b111;
        addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_flags", {30'h0, misalign, bus_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Loads: zero-wait and delayed ack, lane select and extension
        load(3'b010, 32'h100, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        load(3'b010, 32'h104, 2, 32'h0BADF00D, 32'h0BADF00D);
        load(3'b000, 32'h103, 0, 32'h80FF0000, 32'hFFFFFF80);
        load(3'b011, 32'h103, 0, 32'h80FF0000, 32'h00000080);
        load(3'b000, 32'h101, 0, 32'h00007F00, 32'h0000007F);
        load(3'b100, 32'h102, 0, 32'h87654321, 32'h00008765);
        load(3'b001, 32'h102, 0, 32'h87654321, 32'hFFFF8765);

        // Stores: strobes and lane replication
        store(1'b0, 3'b001, 32'h202, 32'h1234ABCD, 32'hABCDABCD, 4'b1100);
        store(1'b0, 3'b000, 32'h201, 32'h000000A5, 32'hA5A5A5A5, 4'b0010);
        store(1'b0, 3'b010, 32'h300, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111);
        store(1'b0, 3'b011, 32'h202, 32'h0000005A, 32'h5A5A5A5A, 4'b0100);
        store(1'b1, 3'b010, 32'h308, 32'h11223344, 32'h11223344, 4'b1111);

        // Misaligned requests and mode 111
        bad_align(1'b1, 1'b0, 3'b010, 32'h101);
        bad_align(1'b1, 1'b0, 3'b001, 32'h103);
        bad_align(1'b0, 1'b1, 3'b010, 32'h302);
        bad_align(1'b0, 1'b1, 3'b001, 32'h205);
        @(posedge clk); #1;
        rd_en = 1'b1; mem_acc_mode = 3'b111; addr = 32'h40;
        @(negedge clk);
        check("none_mode_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rd_en = 1'b0; addr = 32'h0;

        // Timeout with a preceding load so rdata must visibly clear
        load(3'b010, 32'h500, 0, 32'h13579BDF, 32'h13579BDF);
        req_q.push_back(mk_req(32'h400, 1'b1, 32'h55AA55AA, 4'b1111));
        rsp_q.push_back(mk_rsp(32'h0, 1'b1, TO + 1));
        access(1'b0, 1'b1, 3'b010, 32'h400, 32'h55AA55AA, -1, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("stray_ack_rdata", rdata, 32'h0);
        check("stray_ack_stall", 32'(stall), 32'h0);
        check("stray_ack_req", 32'(mem_req), 32'h0);

        // Reset while the bus request is outstanding
        req_q.push_back(mk_req(32'h600, 1'b0, 32'h0, 4'b0000));
        @(posedge clk); #1;
        rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h600;
        @(posedge clk); #1;
        rd_en = 1'b0; mem_acc_mode = 3'b111; addr = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req", 32'(mem_req), 32'h0);
        check("post_rst_stall", 32'(stall), 32'h0);
        load(3'b001, 32'h10, 0, 32'h55558001, 32'hFFFF8001);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("req_q_left", 32'(req_q.size()), 32'h0);
        check("rsp_q_left", 32'(rsp_q.size()), 32'h0);
        check("mis_q_left", 32'(mis_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
